int_to_float_seq: RTL and testbench

- Multi-cycle converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision.
- It is the producer counterpart to the float adder datapath and feeds packed floats into it.
- Uses an iterative left-shift normaliser with a per-cycle shift budget, round-to-nearest-even, and valid/ready handshakes on both sides.
- Sits between the integer execution lanes and the FP lane of the VLIW datapath.

---
 rtl/int_to_float_seq.sv | 139 +++++++++++++
 tb/tb_int_to_float_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/int_to_float_seq.sv
// Iterative 32-bit integer (signed/unsigned) to IEEE-754 single converter with RNE rounding.
// Optional ITOF_INEXACT_FLAG_EN adds an inexact flag output valid alongside out_valid.
module int_to_float_seq #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
`ifdef ITOF_INEXACT_FLAG_EN
  output logic        inexact,
`endif
  output logic        busy
);

  localparam int unsigned SC_W = 6;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            sign_q, sign_d;
  logic [31:0]     mag_q, mag_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            busy_q, busy_d;
  logic            inexact_q, inexact_d;

  logic [31:0] in_mag;
  logic        in_sign;
  logic        guard, sticky, round_up;
  logic [23:0] man_sum;
  logic [7:0]  exp_base, exp_rnd;

  // Operand magnitude and sign at the input boundary
  always_comb begin
    in_sign = in_signed & in_data[31];
    in_mag  = in_sign ? (~in_data + 32'd1) : in_data;
  end

  // Round-to-nearest-even on the normalised magnitude
  always_comb begin
    guard    = mag_q[7];
    sticky   = |mag_q[6:0];
    round_up = guard & (sticky | mag_q[8]);
    man_sum  = {1'b0, mag_q[30:8]} + 24'(round_up);
    exp_base = 8'd158 - {2'b00, sc_q};
    exp_rnd  = exp_base + 8'(man_sum[23]);
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    sc_d       = sc_q;
    out_data_d = out_data_q;
    inexact_d  = inexact_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_sign;
          mag_d   = in_mag;
          sc_d    = '0;
          // Zero skips the normaliser; ROUND emits +0 for an unnormalised magnitude
          state_d = (in_mag == 32'd0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else if (mag_q[31 -: STEP] == '0) begin
          mag_d = mag_q << STEP;
          sc_d  = sc_q + SC_W'(STEP);
        end else begin
          mag_d = mag_q << 1;
          sc_d  = sc_q + SC_W'(1);
        end
      end
      ROUND: begin
        state_d    = DONE;
        out_data_d = mag_q[31] ? {sign_q, exp_rnd, man_sum[22:0]} : 32'd0;
        inexact_d  = guard | sticky;
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          inexact_d = 1'b0;
        end
      end
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      sc_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      sc_q        <= sc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      inexact_q   <= inexact_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
`ifdef ITOF_INEXACT_FLAG_EN
  assign inexact   = inexact_q;
`else
  logic unused_inexact;
  assign unused_inexact = inexact_q;
`endif

endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed bench for int_to_float_seq: STEP=1 and STEP=4 instances driven in lockstep.
module tb_int_to_float_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_ready;
  logic        in_ready1, out_valid1, busy1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data1, out_data4;
`ifdef ITOF_INEXACT_FLAG_EN
  logic        inexact1, inexact4;
`endif

  int checks = 0;
  int errors = 0;
  int xfer1  = 0;

  always #5 clk = ~clk;

  int_to_float_seq #(.STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1),
`ifdef ITOF_INEXACT_FLAG_EN
    .inexact(inexact1),
`endif
    .busy(busy1)
  );

  int_to_float_seq #(.STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4),
`ifdef ITOF_INEXACT_FLAG_EN
    .inexact(inexact4),
`endif
    .busy(busy4)
  );

  always @(posedge clk) if (out_valid1 && out_ready) xfer1 <= xfer1 + 1;

  typedef struct {
    logic [31:0] din;
    logic        sgn;
    logic [31:0] dout;
    logic        inx;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operand, then wait (bounded) for out_valid on both instances with out_ready low
  task automatic do_op(input logic [31:0] d, input logic s, output int l1, output int l4);
    @(negedge clk);
    in_data = d; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_in_ready", 32'(in_ready1), 32'd0);
    chk("accept_busy", 32'(busy1), 32'd1);
    l1 = -1; l4 = -1;
    for (int c = 1; c <= 100 && (l1 < 0 || l4 < 0); c++) begin
      @(posedge clk); #1;
      if (l1 < 0 && out_valid1) l1 = c;
      if (l4 < 0 && out_valid4) l4 = c;
    end
  endtask

  task automatic release_op(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_ov_drop"}, 32'(out_valid1), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready1 & in_ready4), 32'd1);
`ifdef ITOF_INEXACT_FLAG_EN
    chk({name, "_inexact_clr"}, 32'(inexact1 | inexact4), 32'd0);
`endif
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int l1, l4, x0;
    vecs[0]  = '{32'h00000001, 1'b0, 32'h3F800000, 1'b0, 33, 12};
    vecs[1]  = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 33, 12};
    vecs[2]  = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0,  2,  2};
    vecs[3]  = '{32'h80000000, 1'b0, 32'h4F000000, 1'b0,  2,  2};
    vecs[4]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0,  1,  1};
    vecs[5]  = '{32'h00000000, 1'b1, 32'h00000000, 1'b0,  1,  1};
    vecs[6]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1,  9,  6};
    vecs[7]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1,  9,  6};
    vecs[8]  = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1,  2,  2};
    vecs[9]  = '{32'h00000005, 1'b0, 32'h40A00000, 1'b0, 31, 10};
    vecs[10] = '{32'hFFFFFF00, 1'b1, 32'hC3800000, 1'b0, 25, 10};
    vecs[11] = '{32'h7FFFFFFF, 1'b0, 32'h4F000000, 1'b1,  3,  3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready1 & in_ready4), 32'd1);
    chk("rst_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    chk("rst_out_data", out_data1 | out_data4, 32'd0);
    chk("rst_busy", 32'(busy1 | busy4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].din, vecs[i].sgn, l1, l4);
      chk($sformatf("v%0d_data_s1", i), out_data1, vecs[i].dout);
      chk($sformatf("v%0d_data_s4", i), out_data4, vecs[i].dout);
      chk_int($sformatf("v%0d_lat_s1", i), l1, vecs[i].lat1);
      chk_int($sformatf("v%0d_lat_s4", i), l4, vecs[i].lat4);
`ifdef ITOF_INEXACT_FLAG_EN
      chk($sformatf("v%0d_inexact_s1", i), 32'(inexact1), 32'(vecs[i].inx));
      chk($sformatf("v%0d_inexact_s4", i), 32'(inexact4), 32'(vecs[i].inx));
`endif
      release_op($sformatf("v%0d", i));
    end

    // Backpressure: result held for 5 cycles while a competing input is ignored
    do_op(32'h01000003, 1'b0, l1, l4);
    chk_int("bp_lat_s1", l1, 9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_signed = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid1), 32'd1);
      chk($sformatf("bp%0d_out_data", k), out_data1, 32'h4B800002);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready1), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    x0 = xfer1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ov", 32'(out_valid1), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk_int("bp_transfers", xfer1 - x0, 1);
    chk("bp_idle_busy", 32'(busy1 | busy4), 32'd0);
    chk("bp_idle_ov", 32'(out_valid1 | out_valid4), 32'd0);

    // Reset in the middle of normalisation, with in_valid asserted
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000001; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h00000005;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 32'(in_ready1 & in_ready4), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    chk("mid_rst_busy", 32'(busy1 | busy4), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid1 | out_valid4), 32'd0);
    do_op(32'h00000005, 1'b0, l1, l4);
    chk("post_rst_data_s1", out_data1, 32'h40A00000);
    chk("post_rst_data_s4", out_data4, 32'h40A00000);
    chk_int("post_rst_lat_s1", l1, 31);
    chk_int("post_rst_lat_s4", l4, 10);
    release_op("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
